alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised, registered ALU for the toycpu datapath; next generation of the single-cycle ADD/MV ALU. It adds subtract, logic ops, multi-cycle shifts and an optional iterative multiplier. A start/busy/done handshake lets the control FSM stall on multi-cycle ops. Carry, zero and negative flags are held in registers and change only on arithmetic ops.

## Interface
- WIDTH, 16: operand/result width, ≥ 4.
- SHW, $clog2(WIDTH): shift-amount width, derived; do not override.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  6  opcode, sampled with start.
- in1  in  WIDTH  operand A, sampled with start.
- in2  in  WIDTH  operand B / shift amount (low SHW bits), sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: out/flags valid this cycle.
- out  out  WIDTH  registered result, held until next done.
- cFlag, zFlag, nFlag  out  1 each  registered flags.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL, 63 MV (out=in1). Any other opcode is illegal: out=0, flags hold.
- ADD: out = (in1+in2)[WIDTH-1:0]; C = bit WIDTH of the WIDTH+1-bit sum.
- SUB: in1 + ~in2 + 1; C = 1 means no borrow (in1 ≥ in2 unsigned).
- MUL: unsigned product, 2·WIDTH bits internally; out = low half; C = (high half ≠ 0).
- Z = (out == 0) and N = out[WIDTH-1]. Both update only on ADD, SUB and MUL. C updates on the same ops.
- AND, OR, XOR, SHL, SHR, MV and illegal opcodes leave all flags unchanged.
- Shifts: amount = in2[SHW-1:0]. One bit position per cycle. Shifted-in bits are 0.
- FSM states: IDLE, SHIFT, MUL, DONE.
  - IDLE with start: operands are latched and busy=1 from the next cycle.
  - Single-cycle ops and amount-0 shifts go straight to DONE.
  - SHIFT decrements its counter and exits to DONE when the counter reaches 0.
  - MUL runs WIDTH shift-add steps, then goes to DONE.
  - DONE asserts done for one cycle, writes out and flags, clears busy, and returns to IDLE.
- start while busy=1 is ignored, with no queuing. start in the DONE cycle is also ignored; busy is still 1 there.

## Timing
- Reset values: out=0, cFlag=0, zFlag=0, nFlag=0, busy=0, done=0, state IDLE.
- Reset asserted mid-operation aborts immediately. No done is produced and no flag is written.
- Latency is counted from the start-sampling edge to the done cycle:
  - Single-cycle ops and amount-0 shifts: 1 cycle (done high the cycle after start).
  - Shifts by k: k+1 cycles.
  - MUL: WIDTH+1 cycles.
- Throughput: a new start is accepted no sooner than the cycle after done.
- out and flags change only on the edge ending the DONE cycle's predecessor. They are stable in the done cycle and hold otherwise.

## Configuration
- ALU_MUL_EN defined: opcode 7 runs the iterative multiplier (MUL state, multiplier sub-module instantiated).
- ALU_MUL_EN undefined: the multiplier logic and MUL state are absent. Opcode 7 is treated as illegal: 1-cycle latency, out=0, flags hold.

## Structure
- Package alu_pkg holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL, OP_MV;
  - the FSM state enum;
  - the 6-bit opcode typedef.
- Sub-module alu_mul_iter: shift-add multiplier with go/busy/ready, parametrised by WIDTH. It is instantiated only under ALU_MUL_EN.
- Top-level alu_iter holds the FSM, the single-cycle datapath, the shifter counter and the flag registers.

## Test plan
- Reset: drive rst_n=0 mid-MUL.
  - Outputs read 0 and busy=0 immediately.
  - After release, no spurious done occurs.
- ADD, WIDTH=16: 0xFFFF+0x0001 -> out=0x0000, C=1, Z=1, N=0, done 1 cycle after start.
- Then AND 0x00F0&0x0F00 -> out=0x0000 and flags still C=1, Z=1.
- SUB: 0x0003-0x0005 -> out=0xFFFE, C=0, Z=0, N=1.
- SUB: 0x0005-0x0005 -> out=0, C=1, Z=1.
- SHL: in1=0x0001, in2=5 -> out=0x0020 with done 6 cycles after start.
- SHR by 0 -> out=in1 in 1 cycle.
- A start pulsed while busy is ignored.
- MUL (ALU_MUL_EN): 0x0100×0x0100 -> out=0x0000, C=1, Z=1 after 17 cycles.
- MUL without the macro: opcode 7 -> out=0, flags unchanged, 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pkg : opcodes, opcode type and FSM states for alu_iter (ALU_MUL_EN)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package alu_pkg;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_ADD = 6'd0;
    localparam opcode_t OP_SUB = 6'd1;
    localparam opcode_t OP_AND = 6'd2;
    localparam opcode_t OP_OR  = 6'd3;
    localparam opcode_t OP_XOR = 6'd4;
    localparam opcode_t OP_SHL = 6'd5;
    localparam opcode_t OP_SHR = 6'd6;
    localparam opcode_t OP_MUL = 6'd7;
    localparam opcode_t OP_MV  = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
`ifdef ALU_MUL_EN
        , ST_MUL = 2'd3
`endif
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_mul_iter : WIDTH-step shift-add unsigned multiplier, go/busy/ready    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] p_q, p_d, p_step;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [WIDTH:0]     step_sum;

    // Low half starts as the multiplier and is consumed LSB-first as the
    // partial product shifts in from the top.
    always_comb begin
        step_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
        p_step   = {step_sum, p_q[WIDTH-1:1]};
        p_d      = p_q;
        a_d      = a_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (go) begin
            p_d    = {{WIDTH{1'b0}}, b};
            a_d    = a;
            cnt_d  = CW'(WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            p_d   = p_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= '0;
            a_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            a_q    <= a_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // ready flags the final step so the caller can capture the product on
    // the same edge that completes it.
    assign busy    = busy_q;
    assign ready   = busy_q && (cnt_q == CW'(1));
    assign product = p_step;

endmodule
`default_nettype wire

// File: rtl/alu_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_iter : registered multi-cycle ALU with start/busy/done (ALU_MUL_EN)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  opcode_t          op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cFlag,
    output logic             zFlag,
    output logic             nFlag
);
    state_t             state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]   out_q, out_d, shreg_q, shreg_d, shifted;
    logic [SHW-1:0]     cnt_q, cnt_d, amount;
    logic               shr_q, shr_d, c_q, c_d, z_q, z_d, n_q, n_d, is_sub;
    logic [WIDTH:0]     sum;

`ifdef ALU_MUL_EN
    logic               mul_go, mul_busy, mul_ready;
    logic [2*WIDTH-1:0] mul_prod;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (mul_go),
        .a       (in1),
        .b       (in2),
        .busy    (mul_busy),
        .ready   (mul_ready),
        .product (mul_prod)
    );
`endif

    always_comb begin
        is_sub  = (op == OP_SUB);
        sum     = {1'b0, in1} + {1'b0, is_sub ? ~in2 : in2} + {{WIDTH{1'b0}}, is_sub};
        shifted = shr_q ? (shreg_q >> 1) : (shreg_q << 1);
        amount  = in2[SHW-1:0];
        state_d = state_q;
        busy_d  = busy_q;
        out_d   = out_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        shr_d   = shr_q;
        c_d     = c_q;
        z_d     = z_q;
        n_d     = n_q;
`ifdef ALU_MUL_EN
        mul_go  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    state_d = ST_DONE;
                    case (op)
                        OP_ADD, OP_SUB: begin
                            out_d = sum[WIDTH-1:0];
                            c_d   = sum[WIDTH];
                            z_d   = (sum[WIDTH-1:0] == '0);
                            n_d   = sum[WIDTH-1];
                        end
                        OP_AND: out_d = in1 & in2;
                        OP_OR:  out_d = in1 | in2;
                        OP_XOR: out_d = in1 ^ in2;
                        OP_MV:  out_d = in1;
                        OP_SHL, OP_SHR: begin
                            if (amount == '0) begin
                                out_d = in1;
                            end else begin
                                shreg_d = in1;
                                cnt_d   = amount;
                                shr_d   = (op == OP_SHR);
                                state_d = ST_SHIFT;
                            end
                        end
`ifdef ALU_MUL_EN
                        OP_MUL: begin
                            mul_go  = 1'b1;
                            state_d = ST_MUL;
                        end
`endif
                        default: out_d = '0;
                    endcase
                end
            end
            // The last shift lands directly in out so DONE needs no extra cycle.
            ST_SHIFT: begin
                if (cnt_q == SHW'(1)) begin
                    out_d   = shifted;
                    state_d = ST_DONE;
                end else begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q - SHW'(1);
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                if (mul_busy && mul_ready) begin
                    out_d   = mul_prod[WIDTH-1:0];
                    c_d     = |mul_prod[2*WIDTH-1:WIDTH];
                    z_d     = (mul_prod[WIDTH-1:0] == '0);
                    n_d     = mul_prod[WIDTH-1];
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            shr_q   <= 1'b0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            shr_q   <= shr_d;
            c_q     <= c_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign out   = out_q;
    assign cFlag = c_q;
    assign zFlag = z_q;
    assign nFlag = n_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_iter : scoreboard bench for alu_iter against an arithmetic model   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alu_iter;
    localparam int WIDTH = 16;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [5:0]       op    = '0;
    logic [WIDTH-1:0] in1   = '0;
    logic [WIDTH-1:0] in2   = '0;
    logic             busy, done, cFlag, zFlag, nFlag;
    logic [WIDTH-1:0] out;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             c;
        logic             z;
        logic             n;
        int               due;
        int               op;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic mc = 1'b0, mz = 1'b0, mn = 1'b0;

    alu_iter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .cFlag (cFlag),
        .zFlag (zFlag),
        .nFlag (nFlag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference model: result and flags from plain arithmetic on the operands.
    task automatic send(input logic [5:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t             e;
        longint           full;
        logic [WIDTH-1:0] res;
        logic             c;
        logic             arith;
        int               lat;
        int               amt;
        amt   = int'(b % WIDTH);
        lat   = 1;
        arith = 1'b0;
        c     = 1'b0;
        case (o)
            6'd0: begin
                full  = longint'(a) + longint'(b);
                res   = WIDTH'(full);
                c     = (full >= (longint'(1) << WIDTH));
                arith = 1'b1;
            end
            6'd1: begin
                res   = WIDTH'(longint'(a) - longint'(b));
                c     = (a >= b);
                arith = 1'b1;
            end
            6'd2: res = a & b;
            6'd3: res = a | b;
            6'd4: res = a ^ b;
            6'd5: begin res = WIDTH'(longint'(a) << amt); lat = amt + 1; end
            6'd6: begin res = a >> amt; lat = amt + 1; end
`ifdef ALU_MUL_EN
            6'd7: begin
                full  = longint'(a) * longint'(b);
                res   = WIDTH'(full);
                c     = ((full >> WIDTH) != 0);
                arith = 1'b1;
                lat   = WIDTH + 1;
            end
`endif
            6'd63:   res = a;
            default: res = '0;
        endcase
        if (arith) begin
            mc = c;
            mz = (res == '0);
            mn = res[WIDTH-1];
        end
        e.out = res; e.c = mc; e.z = mz; e.n = mn;
        e.due = cyc + lat;
        e.op  = int'(o);
        q.push_back(e);
        start = 1'b1; op = o; in1 = a; in2 = b;
    endtask

    // Waits for busy to drop, meanwhile pulsing junk starts that must be ignored.
    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (busy) begin
                start = ($urandom_range(0, 1) == 1);
                op    = 6'($urandom);
                in1   = WIDTH'($urandom);
                in2   = WIDTH'($urandom);
            end
        end while (busy && n < 64);
        start = 1'b0;
        if (busy) begin
            total++; bad++;
            $display("FAIL busy_timeout: busy still %0d after %0d cycles, want 0", busy, n);
        end
    endtask

    task automatic run(input logic [5:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        send(o, a, b);
        wait_idle();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_done: got done=1 with nothing pending, want 0 (t=%0t)", $time);
            end else begin
                e = q.pop_front();
                chk($sformatf("op%0d_out", e.op), longint'(out), longint'(e.out));
                chk($sformatf("op%0d_c", e.op), longint'(cFlag), longint'(e.c));
                chk($sformatf("op%0d_z", e.op), longint'(zFlag), longint'(e.z));
                chk($sformatf("op%0d_n", e.op), longint'(nFlag), longint'(e.n));
                chk($sformatf("op%0d_latency", e.op), longint'(cyc), longint'(e.due));
            end
        end
    end

    initial begin
        #1_000_000;
        total++; bad++;
        $display("FAIL watchdog: simulation still running at t=%0t, want finished", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [5:0]       o;
        logic [WIDTH-1:0] a, b;
        int               r;

        #2;
        chk("rst_out", longint'(out), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_c", longint'(cFlag), 0);
        chk("rst_z", longint'(zFlag), 0);
        chk("rst_n_flag", longint'(nFlag), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(6'd0, 16'hFFFF, 16'h0001);
        run(6'd2, 16'h00F0, 16'h0F00);
        run(6'd1, 16'h0003, 16'h0005);
        run(6'd1, 16'h0005, 16'h0005);
        run(6'd5, 16'h0001, 16'h0005);
        run(6'd6, 16'hA5C3, 16'h0000);
        run(6'd6, 16'h8000, 16'h000F);
        run(6'd7, 16'h0100, 16'h0100);
        run(6'd20, 16'h1234, 16'h5678);
        run(6'd63, 16'hBEEF, 16'h0000);

        // Abort a long operation with an asynchronous reset.
        run(6'd1, 16'h0003, 16'h0005);
`ifdef ALU_MUL_EN
        send(6'd7, 16'h1234, 16'h4321);
`else
        send(6'd5, 16'h0003, 16'h000F);
`endif
        repeat (5) @(posedge clk);
        start = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("abort_out", longint'(out), 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_done", longint'(done), 0);
        chk("abort_n", longint'(nFlag), 0);
        q.delete();
        mc = 1'b0; mz = 1'b0; mn = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("post_abort_busy", longint'(busy), 0);
        chk("post_abort_out", longint'(out), 0);

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 10);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            if (r <= 7)       o = 6'(r);
            else if (r == 8)  o = 6'd63;
            else if (r == 9)  o = 6'($urandom_range(8, 62));
            else              o = 6'd5;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 5) == 0) a = '0;
            run(o, a, b);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", longint'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
